exec_wb: RTL and testbench

EXEC_WB -- requirements
Module: exec_wb

---
 rtl/exec_wb.sv | 217 +++++++++++++++++++++
 tb/tb_exec_wb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_wb.sv
// exec_wb: ALU execute stage plus register-file write-back sequencer.
// Define EXEC_WB_MUL_EN to add the 8-cycle shift-add multiply for OP=111.
module exec_wb (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [2:0] OP,
  input  logic [7:0] OPA,
  input  logic [7:0] OPB,
  input  logic [7:0] OPC,
  input  logic [1:0] DST,
  output logic [7:0] RESULT,
  output logic       MRWE,
  output logic       WA1,
  output logic       WA0,
  output logic       BUSY,
  output logic       DONE,
  output logic [3:0] FLAGS
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;

`ifdef EXEC_WB_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2,
    S_MUL  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;
`endif

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       cin_q, cin_d;
  logic [1:0] dst_q, dst_d;
  logic [7:0] result_q, result_d;
  logic [3:0] flags_q, flags_d;
  logic       mrwe_q, mrwe_d;
  logic       done_q, done_d;

  // Only the carry-in bit of the constant port matters.
  logic unused_opc;
  assign unused_opc = ^OPC[7:1];

  logic [7:0] addend;
  logic [8:0] sum;
  logic [7:0] alu_res;
  logic       alu_c;
  logic       alu_v;
  logic       alu_wr;

  always_comb begin
    addend  = (op_q == OP_SUB) ? ~b_q : b_q;
    sum     = {1'b0, a_q} + {1'b0, addend}
            + {8'h00, cin_q};
    alu_res = 8'h00;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_wr  = 1'b1;
    case (op_q)
      OP_ADD, OP_SUB: begin
        alu_res = sum[7:0];
        alu_c   = sum[8];
        alu_v   = (a_q[7] == addend[7])
                && (sum[7] != a_q[7]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: begin
        alu_res = {a_q[6:0], cin_q};
        alu_c   = a_q[7];
      end
      OP_SHR: begin
        alu_res = {cin_q, a_q[7:1]};
        alu_c   = a_q[0];
      end
      default: alu_wr = 1'b0;
    endcase
  end

`ifdef EXEC_WB_MUL_EN
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] prod_q, prod_d;
  logic [8:0]  mul_sum;
  logic [15:0] prod_step;

  // Right-shifting product register: {partial, multiplier}.
  always_comb begin
    mul_sum   = {1'b0, prod_q[15:8]}
              + (prod_q[0] ? {1'b0, a_q} : 9'h000);
    prod_step = {mul_sum, prod_q[7:1]};
  end
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    dst_d    = dst_q;
    result_d = result_q;
    flags_d  = flags_q;
    mrwe_d   = 1'b0;
    done_d   = 1'b0;
`ifdef EXEC_WB_MUL_EN
    cnt_d    = cnt_q;
    prod_d   = prod_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          op_d    = OP;
          a_d     = OPA;
          b_d     = OPB;
          cin_d   = OPC[0];
          dst_d   = DST;
          state_d = S_EXEC;
`ifdef EXEC_WB_MUL_EN
          if (OP == OP_MUL) begin
            state_d = S_MUL;
            cnt_d   = 3'd0;
            prod_d  = {8'h00, OPB};
          end
`endif
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        done_d  = 1'b1;
        mrwe_d  = alu_wr;
        if (alu_wr) begin
          result_d = alu_res;
          flags_d  = {alu_res == 8'h00, alu_res[7],
                      alu_c, alu_v};
        end
      end
`ifdef EXEC_WB_MUL_EN
      S_MUL: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d  = S_WB;
          done_d   = 1'b1;
          mrwe_d   = 1'b1;
          result_d = prod_step[7:0];
          flags_d  = {prod_step[7:0] == 8'h00,
                      prod_step[7],
                      |prod_step[15:8], 1'b0};
        end
      end
`endif
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      op_q     <= 3'b000;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      cin_q    <= 1'b0;
      dst_q    <= 2'b00;
      result_q <= 8'h00;
      flags_q  <= 4'b0000;
      mrwe_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef EXEC_WB_MUL_EN
      cnt_q    <= 3'd0;
      prod_q   <= 16'h0000;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      dst_q    <= dst_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      mrwe_q   <= mrwe_d;
      done_q   <= done_d;
`ifdef EXEC_WB_MUL_EN
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
`endif
    end
  end

  assign RESULT = result_q;
  assign FLAGS  = flags_q;
  assign MRWE   = mrwe_q;
  assign DONE   = done_q;
  assign WA1    = dst_q[1];
  assign WA0    = dst_q[0];
  assign BUSY   = (state_q != S_IDLE);

endmodule

// File: tb/tb_exec_wb.sv
// tb_exec_wb: vector table + scoreboard bench for exec_wb.
// Expected write-backs are queued at START and popped on DONE.
`timescale 1ns/1ps
module tb_exec_wb;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [1:0] dst;
    logic [7:0] res;
    logic [3:0] flg;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] res;
    logic       chk_res;
    logic       we;
    logic [1:0] wa;
    logic [3:0] flg;
  } exp_t;

  localparam int NV = 14;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [2:0] OP;
  logic [7:0] OPA, OPB, OPC;
  logic [1:0] DST;
  logic [7:0] RESULT;
  logic       MRWE, WA1, WA0;
  logic       BUSY, DONE;
  logic [3:0] FLAGS;

  exec_wb dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .OP(OP), .OPA(OPA), .OPB(OPB), .OPC(OPC),
    .DST(DST), .RESULT(RESULT), .MRWE(MRWE),
    .WA1(WA1), .WA0(WA0), .BUSY(BUSY),
    .DONE(DONE), .FLAGS(FLAGS)
  );

  always #5 CLK = ~CLK;

  int   checks   = 0;
  int   errors   = 0;
  int   mrwe_cnt = 0;
  exp_t sb[$];
  vec_t vec[NV];

  task automatic chk(input int id, input string nm,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL id=%0d %s act=%0h exp=%0h",
               id, nm, act, exp);
    end
  endtask

  task automatic reset_chk(input int id);
    chk(id, "rst_result", int'(RESULT), 0);
    chk(id, "rst_flags", int'(FLAGS), 0);
    chk(id, "rst_wa", int'({WA1, WA0}), 0);
    chk(id, "rst_busy_done_mrwe",
        int'({BUSY, DONE, MRWE}), 0);
  endtask

  always @(negedge CLK) begin : mon
    exp_t e;
    if (MRWE) mrwe_cnt++;
    if (DONE) begin
      if (sb.size() == 0) begin
        chk(-1, "done_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        chk(e.id, "mrwe", int'(MRWE), int'(e.we));
        chk(e.id, "wa", int'({WA1, WA0}), int'(e.wa));
        chk(e.id, "flags", int'(FLAGS), int'(e.flg));
        if (e.chk_res)
          chk(e.id, "result", int'(RESULT), int'(e.res));
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after IDLE.
  task automatic do_op(input int id, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [1:0] dst,
                       input logic [7:0] res, input logic chk_res,
                       input logic we, input logic [3:0] flg,
                       input int lat);
    exp_t e;
    int   n;
    int   busy_n;
    int   m0;
    logic got;
    e.id = id; e.res = res; e.chk_res = chk_res;
    e.we = we; e.wa = dst; e.flg = flg;
    sb.push_back(e);
    m0 = mrwe_cnt;
    START = 1'b1; OP = op; OPA = a; OPB = b;
    OPC = {8{cin}}; DST = dst;
    n = 0; busy_n = 0; got = 1'b0;
    while (!got && n < 24) begin
      @(negedge CLK);
      n++;
      if (BUSY) busy_n++;
      got = DONE;
      START = 1'b1;
      OP  = 3'($urandom);
      OPA = 8'($urandom);
      OPB = 8'($urandom);
      OPC = 8'($urandom);
      DST = 2'($urandom);
    end
    chk(id, "latency", n, lat);
    chk(id, "busy_cycles", busy_n, lat);
    @(negedge CLK);
    START = 1'b0;
    chk(id, "idle_after", int'({BUSY, DONE, MRWE}), 0);
    chk(id, "mrwe_pulses", mrwe_cnt - m0, int'(we));
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : main
    int m0;
    vec[0]  = '{3'b000, 8'h7F, 8'h01, 1'b0, 2'b01, 8'h80, 4'b0101};
    vec[1]  = '{3'b001, 8'h05, 8'h05, 1'b1, 2'b00, 8'h00, 4'b1010};
    vec[2]  = '{3'b001, 8'h00, 8'h01, 1'b1, 2'b10, 8'hFF, 4'b0100};
    vec[3]  = '{3'b101, 8'h81, 8'h5A, 1'b1, 2'b11, 8'h03, 4'b0010};
    vec[4]  = '{3'b110, 8'h01, 8'hA5, 1'b0, 2'b00, 8'h00, 4'b1010};
    vec[5]  = '{3'b010, 8'hF0, 8'h3C, 1'b1, 2'b01, 8'h30, 4'b0000};
    vec[6]  = '{3'b011, 8'h80, 8'h01, 1'b0, 2'b10, 8'h81, 4'b0100};
    vec[7]  = '{3'b100, 8'hAA, 8'hAA, 1'b1, 2'b11, 8'h00, 4'b1000};
    vec[8]  = '{3'b000, 8'hFF, 8'h01, 1'b1, 2'b00, 8'h01, 4'b0010};
    vec[9]  = '{3'b000, 8'h80, 8'h80, 1'b0, 2'b01, 8'h00, 4'b1011};
    vec[10] = '{3'b001, 8'h80, 8'h01, 1'b1, 2'b10, 8'h7F, 4'b0011};
    vec[11] = '{3'b001, 8'h10, 8'h01, 1'b0, 2'b11, 8'h0E, 4'b0010};
    vec[12] = '{3'b110, 8'h80, 8'h00, 1'b1, 2'b00, 8'hC0, 4'b0100};
    vec[13] = '{3'b101, 8'h40, 8'hFF, 1'b0, 2'b01, 8'h80, 4'b0100};

    RESET = 1'b1; START = 1'b0; OP = 3'b000;
    OPA = 8'h00; OPB = 8'h00; OPC = 8'h00; DST = 2'b00;
    repeat (2) @(negedge CLK);
    reset_chk(100);
    RESET = 1'b0;

    for (int i = 0; i < NV; i++)
      do_op(i, vec[i].op, vec[i].a, vec[i].b, vec[i].cin,
            vec[i].dst, vec[i].res, 1'b1, 1'b1,
            vec[i].flg, 2);

`ifdef EXEC_WB_MUL_EN
    do_op(200, 3'b111, 8'h10, 8'h20, 1'b0, 2'b10,
          8'h00, 1'b1, 1'b1, 4'b1010, 9);
    do_op(201, 3'b111, 8'h0C, 8'h0A, 1'b1, 2'b11,
          8'h78, 1'b1, 1'b1, 4'b0000, 9);
    do_op(202, 3'b111, 8'hFF, 8'hFF, 1'b0, 2'b01,
          8'h01, 1'b1, 1'b1, 4'b0010, 9);

    // Abort a multiply in its fourth cycle.
    m0 = mrwe_cnt;
    START = 1'b1; OP = 3'b111;
    OPA = 8'h33; OPB = 8'h07; OPC = 8'h00; DST = 2'b11;
    @(posedge CLK);
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b1;
    #1 reset_chk(203);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    chk(203, "mul_abort_no_write", mrwe_cnt - m0, 0);
    do_op(204, 3'b111, 8'h0C, 8'h0A, 1'b0, 2'b10,
          8'h78, 1'b1, 1'b1, 4'b0000, 9);
`else
    // Unimplemented multiply: done pulse only, flags hold.
    do_op(200, 3'b111, 8'h33, 8'h44, 1'b1, 2'b10,
          8'h00, 1'b0, 1'b0, 4'b0100, 2);
`endif

    // Abort in EXEC: async clear, no write.
    m0 = mrwe_cnt;
    START = 1'b1; OP = 3'b000;
    OPA = 8'h01; OPB = 8'h02; OPC = 8'h00; DST = 2'b11;
    @(posedge CLK);
    #2 START = 1'b0; RESET = 1'b1;
    #1 reset_chk(300);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    chk(300, "exec_abort_no_write", mrwe_cnt - m0, 0);
    do_op(301, 3'b100, 8'h0F, 8'hF0, 1'b0, 2'b10,
          8'hFF, 1'b1, 1'b1, 4'b0100, 2);

    // Abort during the write-back cycle itself.
    m0 = mrwe_cnt;
    START = 1'b1; OP = 3'b011;
    OPA = 8'h12; OPB = 8'h21; OPC = 8'h00; DST = 2'b01;
    @(posedge CLK);
    #2 START = 1'b0;
    @(posedge CLK);
    #2 chk(400, "wb_mrwe_before_rst", int'(MRWE), 1);
    RESET = 1'b1;
    #1 reset_chk(400);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    chk(400, "wb_abort_no_write", mrwe_cnt - m0, 0);
    do_op(401, 3'b001, 8'h05, 8'h05, 1'b1, 2'b00,
          8'h00, 1'b1, 1'b1, 4'b1010, 2);

    chk(500, "scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
